// File: rtl/sr_mdu_pkg.sv
// Shared encodings for the schoolRISCV multiply/divide unit: op field values and FSM states.
package sr_mdu_pkg;

    localparam logic [1:0] MDU_MUL    = 2'd0;
    localparam logic [1:0] MDU_MULH   = 2'd1;
    localparam logic [1:0] MDU_DIV    = 2'd2;
    localparam logic [1:0] MDU_REM    = 2'd3;
    localparam int         MDU_SIGNED = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sr_mdu_if.sv
// Start/busy/done request bundle between the core (master) and the multiply/divide unit (slave).
interface sr_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;

    modport master (output start, op, a, b, input busy, done, res);
    modport slave  (input start, op, a, b, output busy, done, res);
endinterface

// File: rtl/sr_mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor and keep the difference only when it does not go negative.
module sr_mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    logic [WIDTH:0] w_sh;

    // Remainder stays below the divisor, so the subtracted value always fits in WIDTH bits.
    assign w_sh   = {i_rem, i_bit};
    assign o_qbit = (w_sh >= {1'b0, i_div});
    assign o_rem  = o_qbit ? (w_sh[WIDTH-1:0] - i_div) : w_sh[WIDTH-1:0];
endmodule

// File: rtl/sr_mdu.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Signed operation (op[2]) exists only when SR_MDU_SIGNED_EN is defined.
module sr_mdu
    import sr_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic    clk_in,
    input  logic    rst_in,
    sr_mdu_if.slave mdu
);
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opd;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_res;

    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_drem;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res;

    assign w_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_lo = r_acc[WIDTH-1:0];

    // Multiply: low half holds the remaining multiplier bits, consumed LSB first.
    assign w_sum      = {1'b0, w_hi} + {1'b0, (w_lo[0] ? r_opd : {WIDTH{1'b0}})};
    assign w_mul_next = {w_sum, w_lo[WIDTH-1:1]};

    sr_mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .i_rem  (w_hi),
        .i_bit  (w_lo[WIDTH-1]),
        .i_div  (r_opd),
        .o_rem  (w_drem),
        .o_qbit (w_qbit)
    );

    assign w_div_next = {w_drem, w_lo[WIDTH-2:0], w_qbit};
    assign w_acc_next = r_op[1] ? w_div_next : w_mul_next;

`ifdef SR_MDU_SIGNED_EN
    logic w_a_neg;
    logic w_b_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_neg = mdu.op[MDU_SIGNED] & mdu.a[WIDTH-1];
    assign w_b_neg = mdu.op[MDU_SIGNED] & mdu.b[WIDTH-1];
    assign w_a_abs = w_a_neg ? (-mdu.a) : mdu.a;
    assign w_b_abs = w_b_neg ? (-mdu.b) : mdu.b;

    // Result signs are fixed at capture; divide by zero keeps the all-ones quotient positive.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if ((r_state == IDLE) && mdu.start) begin
            r_neg_q <= (w_a_neg ^ w_b_neg) & (|mdu.b);
            r_neg_r <= w_a_neg;
        end
    end

    assign w_prod = r_neg_q ? (-w_mul_next) : w_mul_next;
    assign w_quo  = r_neg_q ? (-w_div_next[WIDTH-1:0]) : w_div_next[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (-w_div_next[2*WIDTH-1:WIDTH]) : w_div_next[2*WIDTH-1:WIDTH];
`else
    logic w_unused_sign;

    assign w_unused_sign = mdu.op[MDU_SIGNED];
    assign w_a_abs       = mdu.a;
    assign w_b_abs       = mdu.b;
    assign w_prod        = w_mul_next;
    assign w_quo         = w_div_next[WIDTH-1:0];
    assign w_rem         = w_div_next[2*WIDTH-1:WIDTH];
`endif

    // Result selection for the final iteration.
    always_comb begin
        w_res = {WIDTH{1'b0}};
        case (r_op)
            MDU_MUL:  w_res = w_prod[WIDTH-1:0];
            MDU_MULH: w_res = w_prod[2*WIDTH-1:WIDTH];
            MDU_DIV:  w_res = w_quo;
            MDU_REM:  w_res = w_rem;
            default:  w_res = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM with registered busy/done/res.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_op    <= 2'd0;
            r_opd   <= {WIDTH{1'b0}};
            r_acc   <= {(2*WIDTH){1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_res   <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (mdu.start) begin
                        r_op    <= mdu.op[1:0];
                        r_opd   <= mdu.op[1] ? w_b_abs : w_a_abs;
                        r_acc   <= {{WIDTH{1'b0}}, (mdu.op[1] ? w_a_abs : w_b_abs)};
                        r_cnt   <= CNT_W'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_res   <= w_res;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mdu.busy = r_busy;
    assign mdu.done = r_done;
    assign mdu.res  = r_res;
endmodule

// File: tb/tb_sr_mdu.sv
// Scoreboard bench for sr_mdu at WIDTH=8 and WIDTH=32; expected results follow SR_MDU_SIGNED_EN.
module tb_sr_mdu;
    logic clk = 1'b0;
    logic rst8;
    logic rst32;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  q8[$];
    logic [31:0] q32[$];

    always #5 clk = ~clk;

    sr_mdu_if #(.WIDTH(8))  if8 ();
    sr_mdu_if #(.WIDTH(32)) if32 ();

    sr_mdu #(.WIDTH(8))  dut8  (.clk_in(clk), .rst_in(rst8),  .mdu(if8.slave));
    sr_mdu #(.WIDTH(32)) dut32 (.clk_in(clk), .rst_in(rst32), .mdu(if32.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (if8.done === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: got done=1 res=%h expected no done", if8.res);
            end else begin
                chk("res8", {56'd0, if8.res}, {56'd0, q8.pop_front()});
            end
        end
        if (if32.done === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done32_unexpected: got done=1 res=%h expected no done", if32.res);
            end else begin
                chk("res32", {32'd0, if32.res}, {32'd0, q32.pop_front()});
            end
        end
    end

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input bit inject);
        @(posedge clk); #1;
        if8.start = 1'b1; if8.op = op; if8.a = a; if8.b = b;
        q8.push_back(exp);
        @(posedge clk); #1;
        if8.start = 1'b0; if8.a = 8'h55; if8.b = 8'h33;
        for (int i = 1; i <= 8; i++) begin
            chk("busy8", {63'd0, if8.busy}, 64'd1);
            chk("done8_early", {63'd0, if8.done}, 64'd0);
            if (inject && (i == 3)) begin
                if8.start = 1'b1; if8.op = 3'd2;
            end else begin
                if8.start = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("busy8_end", {63'd0, if8.busy}, 64'd0);
        chk("done8", {63'd0, if8.done}, 64'd1);
        if (inject) begin
            if8.start = 1'b1; if8.op = 3'd3;
            @(posedge clk); #1;
            if8.start = 1'b0;
            chk("busy8_ignored", {63'd0, if8.busy}, 64'd0);
            chk("done8_single", {63'd0, if8.done}, 64'd0);
            chk("res8_hold", {56'd0, if8.res}, {56'd0, exp});
        end
    endtask

    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        @(posedge clk); #1;
        if32.start = 1'b1; if32.op = op; if32.a = a; if32.b = b;
        q32.push_back(exp);
        @(posedge clk); #1;
        if32.start = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            chk("busy32", {63'd0, if32.busy}, 64'd1);
            @(posedge clk); #1;
        end
        chk("done32", {63'd0, if32.done}, 64'd1);
    endtask

    initial begin
        rst8 = 1'b1; rst32 = 1'b1;
        if8.start = 1'b0;  if8.op = 3'd0;  if8.a = 8'd0;   if8.b = 8'd0;
        if32.start = 1'b0; if32.op = 3'd0; if32.a = 32'd0; if32.b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy8", {63'd0, if8.busy}, 64'd0);
        chk("rst_done8", {63'd0, if8.done}, 64'd0);
        chk("rst_res8", {56'd0, if8.res}, 64'd0);
        chk("rst_busy32", {63'd0, if32.busy}, 64'd0);
        chk("rst_res32", {32'd0, if32.res}, 64'd0);
        rst8 = 1'b0; rst32 = 1'b0;

        run8(3'd0, 8'd200, 8'd200, 8'h40, 1'b0);
        run8(3'd1, 8'd200, 8'd200, 8'h9C, 1'b0);
        run8(3'd2, 8'd100, 8'd7,   8'h0E, 1'b0);
        run8(3'd3, 8'd100, 8'd7,   8'h02, 1'b0);
        run8(3'd2, 8'd5,   8'd0,   8'hFF, 1'b0);
        run8(3'd3, 8'd5,   8'd0,   8'h05, 1'b0);
`ifdef SR_MDU_SIGNED_EN
        run8(3'd6, 8'hF9, 8'h02, 8'hFD, 1'b0);
        run8(3'd7, 8'hF9, 8'h02, 8'hFF, 1'b0);
        run8(3'd6, 8'h80, 8'hFF, 8'h80, 1'b0);
        run8(3'd7, 8'h80, 8'hFF, 8'h00, 1'b0);
        run8(3'd5, 8'hFE, 8'h03, 8'hFF, 1'b0);
`else
        run8(3'd6, 8'hF9, 8'h02, 8'h7C, 1'b0);
        run8(3'd7, 8'hF9, 8'h02, 8'h01, 1'b0);
        run8(3'd6, 8'h80, 8'hFF, 8'h00, 1'b0);
        run8(3'd7, 8'h80, 8'hFF, 8'h80, 1'b0);
        run8(3'd5, 8'hFE, 8'h03, 8'h02, 1'b0);
`endif
        run8(3'd4, 8'hFE, 8'h03, 8'hFA, 1'b0);
        run8(3'd6, 8'hF9, 8'h00, 8'hFF, 1'b0);
        run8(3'd7, 8'hF9, 8'h00, 8'hF9, 1'b0);
        run8(3'd0, 8'd200, 8'd200, 8'h40, 1'b1);
        run8(3'd1, 8'd200, 8'd200, 8'h9C, 1'b0);

        run32(3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        // Abort a DIVU with reset in cycle 4; no done may follow.
        @(posedge clk); #1;
        if32.start = 1'b1; if32.op = 3'd2; if32.a = 32'd1000; if32.b = 32'd3;
        @(posedge clk); #1;
        if32.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst32 = 1'b1;
        chk("busy32_pre_rst", {63'd0, if32.busy}, 64'd1);
        @(posedge clk); #1;
        rst32 = 1'b0;
        chk("rst_mid_busy32", {63'd0, if32.busy}, 64'd0);
        chk("rst_mid_done32", {63'd0, if32.done}, 64'd0);
        chk("rst_mid_res32", {32'd0, if32.res}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("idle_busy32", {63'd0, if32.busy}, 64'd0);
        run32(3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
        run32(3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);

        repeat (3) @(posedge clk);
        #1;
        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
